// File: rtl/inst_mem_loader_pkg.sv
// Shared constants and loader state type for the instruction memory loader.
package inst_mem_loader_pkg;

    localparam int unsigned C_XLEN     = 32;
    localparam logic [31:0] C_SENTINEL = 32'hDEADBEEF;
    localparam logic [31:0] C_NOP      = 32'h00000013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } ld_state_e;

endpackage

// File: rtl/inst_fetch_pipe.sv
// Two-stage fetch tracking pipeline: valid, misalign error and NOP-substitute flags, with flush.
module inst_fetch_pipe (
    input  logic clk,
    input  logic rstN,
    input  logic i_flush,
    input  logic i_acc,
    input  logic i_misal,
    input  logic i_oor,
    output logic o_valid,
    output logic o_err,
    output logic o_nop
);

    logic r_v1, r_e1, r_n1;
    logic r_v2, r_e2, r_n2;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_v1 <= 1'b0;
            r_e1 <= 1'b0;
            r_n1 <= 1'b0;
            r_v2 <= 1'b0;
            r_e2 <= 1'b0;
            r_n2 <= 1'b0;
        end else if (i_flush) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            r_v1 <= i_acc;
            r_e1 <= i_misal;
            r_n1 <= i_misal | i_oor;
            r_v2 <= r_v1;
            r_e2 <= r_e1;
            r_n2 <= r_n1;
        end
    end

    assign o_valid = r_v2;
    assign o_err   = r_e2;
    assign o_nop   = r_n2;

endmodule

// File: rtl/inst_mem_loader.sv
// Instruction memory loader: streams a program into RAM, then serves core fetches.
// Optional feature macro: INST_MEM_LOADER_CHECKSUM_EN (XOR checksum of loaded words).
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int unsigned cXLEN     = C_XLEN,
    parameter int unsigned cDepth    = 1024,
    parameter logic [31:0] cSentinel = C_SENTINEL,
    localparam int unsigned AW       = $clog2(cDepth)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             loadStart,
    input  logic             loadValid,
    input  logic [cXLEN-1:0] loadData,
    output logic             loadReady,
    input  logic             fetchReq,
    input  logic [cXLEN-1:0] fetchAddr,
    output logic             fetchReady,
    output logic             fetchValid,
    output logic [cXLEN-1:0] fetchData,
    output logic             fetchErr,
    output logic             memEn,
    output logic             memWen,
    output logic [AW-1:0]    memAddr,
    output logic [cXLEN-1:0] memWdata,
    input  logic [cXLEN-1:0] memRdata,
    output logic             coreRun,
    output logic             loadDone,
    output logic [AW:0]      wordCount,
    output logic             overflowErr
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    ,
    output logic [cXLEN-1:0] loadChecksum
`endif
);

    ld_state_e        r_state, w_state_nxt;
    logic [AW:0]      r_count, w_count_nxt;
    logic             r_done, w_done_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic             r_mem_en, w_mem_en_nxt;
    logic             r_mem_wen, w_mem_wen_nxt;
    logic [AW-1:0]    r_mem_addr, w_mem_addr_nxt;
    logic [cXLEN-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic             r_load_ready, r_fetch_ready;

    logic w_load_entry, w_load_acc, w_is_sent, w_has_room, w_wr;
    logic w_flush, w_fetch_acc, w_misal, w_oor;
    logic w_pipe_valid, w_pipe_err, w_pipe_nop;

    assign w_load_entry = loadStart && (r_state == ST_IDLE || r_state == ST_RUN);
    assign w_load_acc   = loadValid && r_load_ready;
    assign w_is_sent    = (loadData == cXLEN'(cSentinel));
    assign w_has_room   = (r_count < (AW+1)'(cDepth));
    assign w_wr         = (r_state == ST_LOAD) && w_load_acc && !w_is_sent && w_has_room;
    assign w_flush      = (r_state == ST_RUN) && loadStart;
    assign w_fetch_acc  = fetchReq && r_fetch_ready && !w_flush;
    assign w_misal      = (fetchAddr[1:0] != 2'b00);
    assign w_oor        = (fetchAddr >= cXLEN'(cDepth * 4));

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state       <= ST_IDLE;
            r_count       <= '0;
            r_done        <= 1'b0;
            r_ovf         <= 1'b0;
            r_mem_en      <= 1'b0;
            r_mem_wen     <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_load_ready  <= 1'b0;
            r_fetch_ready <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_count       <= w_count_nxt;
            r_done        <= w_done_nxt;
            r_ovf         <= w_ovf_nxt;
            r_mem_en      <= w_mem_en_nxt;
            r_mem_wen     <= w_mem_wen_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_mem_wdata   <= w_mem_wdata_nxt;
            r_load_ready  <= (w_state_nxt == ST_LOAD);
            r_fetch_ready <= (w_state_nxt == ST_RUN);
        end
    end

    // Next state plus the single RAM port schedule; LOAD and RUN never share a cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_done_nxt      = r_done;
        w_ovf_nxt       = r_ovf;
        w_mem_en_nxt    = 1'b0;
        w_mem_wen_nxt   = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        if (w_load_entry) begin
            w_state_nxt = ST_LOAD;
            w_count_nxt = '0;
            w_done_nxt  = 1'b0;
            w_ovf_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_load_acc) begin
                        if (w_is_sent) begin
                            w_state_nxt = ST_RUN;
                            w_done_nxt  = 1'b1;
                        end else if (w_wr) begin
                            w_mem_en_nxt    = 1'b1;
                            w_mem_wen_nxt   = 1'b1;
                            w_mem_addr_nxt  = r_count[AW-1:0];
                            w_mem_wdata_nxt = loadData;
                            w_count_nxt     = r_count + (AW+1)'(1);
                        end else begin
                            w_ovf_nxt = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_fetch_acc && !w_oor) begin
                        w_mem_en_nxt   = 1'b1;
                        w_mem_addr_nxt = fetchAddr[AW+1:2];
                    end
                end
                default: ;
            endcase
        end
    end

    inst_fetch_pipe u_fetch_pipe (
        .clk     (clk),
        .rstN    (rstN),
        .i_flush (w_flush),
        .i_acc   (w_fetch_acc),
        .i_misal (w_misal),
        .i_oor   (w_oor),
        .o_valid (w_pipe_valid),
        .o_err   (w_pipe_err),
        .o_nop   (w_pipe_nop)
    );

`ifdef INST_MEM_LOADER_CHECKSUM_EN
    logic [cXLEN-1:0] r_checksum;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_checksum <= '0;
        end else if (w_load_entry) begin
            r_checksum <= '0;
        end else if (w_wr) begin
            r_checksum <= r_checksum ^ loadData;
        end
    end

    assign loadChecksum = r_checksum;
`endif

    // RAM read data lands two cycles after acceptance, so it is steered straight through.
    assign fetchValid  = w_pipe_valid;
    assign fetchErr    = w_pipe_valid && w_pipe_err;
    assign fetchData   = !w_pipe_valid ? '0 : (w_pipe_nop ? cXLEN'(C_NOP) : memRdata);
    assign loadReady   = r_load_ready;
    assign fetchReady  = r_fetch_ready;
    assign memEn       = r_mem_en;
    assign memWen      = r_mem_wen;
    assign memAddr     = r_mem_addr;
    assign memWdata    = r_mem_wdata;
    assign coreRun     = r_done;
    assign loadDone    = r_done;
    assign wordCount   = r_count;
    assign overflowErr = r_ovf;

endmodule
